// File: rtl/shiftleds_modes.sv
// Multi-mode LED sequencer: a speed-selectable prescaler steps an N_LEDS pattern
// (rotate left/right, ping-pong, flash) and routes it to a chosen RGB channel.
// Optional build macro SHIFTLEDS_DIM_EN dims the colour channels to 25 % duty.
module shiftleds_modes #(
    parameter int N_LEDS   = 4,
    parameter int NB_SEL   = 2,
    parameter int NB_COUNT = 14
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_SEL-1:0] i_speed_sel,
    input  logic [1:0]        i_mode,
    input  logic [1:0]        i_color_sel,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_r,
    output logic [N_LEDS-1:0] o_led_g,
    output logic [N_LEDS-1:0] o_led_b,
    output logic              o_tick
);

    typedef enum logic [1:0] {
        MODE_ROL   = 2'd0,
        MODE_ROR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_FLASH = 2'd3
    } mode_e;

    localparam logic [NB_COUNT-1:0] COUNT_ONES = '1;
    localparam logic [N_LEDS-1:0]   LED_ONES   = '1;
    localparam logic [N_LEDS-1:0]   LED_LSB    = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]   LED_MSB    = LED_ONES ^ (LED_ONES >> 1);

    logic [NB_COUNT-1:0] count, count_d;
    logic [N_LEDS-1:0]   pattern, pattern_d, step;
    mode_e               mode_q, mode_d, mode_in;
    logic                dir, dir_d;
    logic [NB_SEL:0]     shift_amt;
    logic [NB_COUNT-1:0] limit;
    logic                tick_now;
    logic                dim_on;

    function automatic logic [N_LEDS-1:0] seed(input mode_e m);
        case (m)
            MODE_ROR:   return LED_MSB;
            MODE_FLASH: return LED_ONES;
            default:    return LED_LSB;
        endcase
    endfunction

    // limit(k) = 2^(NB_COUNT-1-k) - 1, i.e. all-ones shifted right by k+1.
    assign shift_amt = {1'b0, i_speed_sel} + {{NB_SEL{1'b0}}, 1'b1};
    assign limit     = COUNT_ONES >> shift_amt;
    assign tick_now  = i_enable && (count >= limit);
    assign mode_in   = mode_e'(i_mode);
    assign step      = dir ? (pattern << 1) : (pattern >> 1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        count_d   = count;
        pattern_d = pattern;
        mode_d    = mode_q;
        dir_d     = dir;
        if (tick_now) begin
            count_d = '0;
            if (mode_in != mode_q) begin
                mode_d    = mode_in;
                dir_d     = 1'b1;
                pattern_d = seed(mode_in);
            end else begin
                case (mode_q)
                    MODE_ROL:   pattern_d = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                    MODE_ROR:   pattern_d = {pattern[0], pattern[N_LEDS-1:1]};
                    MODE_PING: begin
                        pattern_d = step;
                        if (step[N_LEDS-1])
                            dir_d = 1'b0;
                        else if (step[0])
                            dir_d = 1'b1;
                    end
                    MODE_FLASH: pattern_d = (pattern == LED_ONES) ? '0 : LED_ONES;
                    default:    pattern_d = pattern;
                endcase
            end
        end else if (i_enable) begin
            count_d = count + NB_COUNT'(1);
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count   <= '0;
            pattern <= LED_LSB;
            mode_q  <= MODE_ROL;
            dir     <= 1'b1;
            o_tick  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            count   <= count_d;
            pattern <= pattern_d;
            mode_q  <= mode_d;
            dir     <= dir_d;
            o_tick  <= tick_now;
        end
    end

`ifdef SHIFTLEDS_DIM_EN
    logic [1:0] dim_cnt;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            dim_cnt <= '0;
        else
            dim_cnt <= dim_cnt + 2'd1;
    end

    assign dim_on = (dim_cnt == 2'd0);
`else
    assign dim_on = 1'b1;
`endif

    assign o_led = pattern;

    always_comb begin
        o_led_r = '0;
        o_led_g = '0;
        o_led_b = '0;
        if (dim_on) begin
            if (i_color_sel == 2'd0 || i_color_sel == 2'd3) o_led_r = pattern;
            if (i_color_sel == 2'd1 || i_color_sel == 2'd3) o_led_g = pattern;
            if (i_color_sel == 2'd2 || i_color_sel == 2'd3) o_led_b = pattern;
        end
    end

endmodule

// File: tb/tb_shiftleds_modes.sv
// Directed bench for shiftleds_modes with N_LEDS=4, NB_COUNT=6, NB_SEL=2
// (limits 31/15/7/3); honours SHIFTLEDS_DIM_EN when checking colour channels.
module tb_shiftleds_modes;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_speed_sel;
    logic [1:0] i_mode;
    logic [1:0] i_color_sel;
    logic [3:0] o_led, o_led_r, o_led_g, o_led_b;
    logic       o_tick;

    int n_vec = 0;
    int n_err = 0;

    shiftleds_modes #(.N_LEDS(4), .NB_SEL(2), .NB_COUNT(6)) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_speed_sel (i_speed_sel),
        .i_mode      (i_mode),
        .i_color_sel (i_color_sel),
        .o_led       (o_led),
        .o_led_r     (o_led_r),
        .o_led_g     (o_led_g),
        .o_led_b     (o_led_b),
        .o_tick      (o_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        i_reset = 1'b0; i_enable = 1'b1; i_speed_sel = 2'd3;
        i_mode = 2'd0; i_color_sel = 2'd0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (o_led !== 4'b0001) begin n_err++; $display("FAIL reset_led got %b exp %b", o_led, 4'b0001); end
        n_vec++;
        if (o_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b exp 0", o_tick); end
        n_vec++;
        if (o_led_r !== 4'b0001 || o_led_g !== 4'b0000 || o_led_b !== 4'b0000) begin
            n_err++; $display("FAIL reset_colour got r=%b g=%b b=%b exp r=0001 g=0000 b=0000", o_led_r, o_led_g, o_led_b);
        end
    endtask

    task automatic test_rotate_left();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] prev = 4'b0001;
        i_reset = 1'b1;
        foreach (exp_seq[i]) begin
            repeat (3) begin
                @(negedge clock);
                n_vec++;
                if (o_tick !== 1'b0 || o_led !== prev) begin
                    n_err++; $display("FAIL rol_idle step %0d got led=%b tick=%b exp led=%b tick=0", i, o_led, o_tick, prev);
                end
            end
            @(negedge clock);
            n_vec++;
            if (o_led !== exp_seq[i] || o_tick !== 1'b1) begin
                n_err++; $display("FAIL rol_step %0d got led=%b tick=%b exp led=%b tick=1", i, o_led, o_tick, exp_seq[i]);
            end
            prev = exp_seq[i];
        end
    endtask

    task automatic test_ping_pong();
        logic [3:0] exp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0100, 4'b0010, 4'b0001, 4'b0010};
        i_mode = 2'd2;
        foreach (exp_seq[i]) begin
            repeat (4) @(negedge clock);
            n_vec++;
            if (o_led !== exp_seq[i] || o_tick !== 1'b1) begin
                n_err++; $display("FAIL ping_step %0d got led=%b tick=%b exp led=%b tick=1", i, o_led, o_tick, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [3:0] exp_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        foreach (exp_seq[i]) begin
            if (i == 0) i_mode = 2'd0;
            if (i == 3) i_mode = 2'd1;
            repeat (4) @(negedge clock);
            n_vec++;
            if (o_led !== exp_seq[i] || o_tick !== 1'b1) begin
                n_err++; $display("FAIL switch_step %0d got led=%b tick=%b exp led=%b tick=1", i, o_led, o_tick, exp_seq[i]);
            end
        end
    endtask

    task automatic test_speed_change();
        i_speed_sel = 2'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n_vec++;
            if (o_tick !== 1'b0 || o_led !== 4'b0010) begin
                n_err++; $display("FAIL slow_idle cycle %0d got led=%b tick=%b exp led=0010 tick=0", c, o_led, o_tick);
            end
        end
        i_speed_sel = 2'd3;
        @(negedge clock);
        n_vec++;
        if (o_led !== 4'b0001 || o_tick !== 1'b1) begin
            n_err++; $display("FAIL speed_up_tick got led=%b tick=%b exp led=0001 tick=1", o_led, o_tick);
        end
        repeat (3) begin
            @(negedge clock);
            n_vec++;
            if (o_tick !== 1'b0) begin n_err++; $display("FAIL speed_up_idle got tick=%b exp 0", o_tick); end
        end
        @(negedge clock);
        n_vec++;
        if (o_led !== 4'b1000 || o_tick !== 1'b1) begin
            n_err++; $display("FAIL speed_up_next got led=%b tick=%b exp led=1000 tick=1", o_led, o_tick);
        end
    endtask

    task automatic test_enable_freeze();
        repeat (2) @(negedge clock);
        i_enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_vec++;
            if (o_led !== 4'b1000 || o_tick !== 1'b0) begin
                n_err++; $display("FAIL freeze cycle %0d got led=%b tick=%b exp led=1000 tick=0", c, o_led, o_tick);
            end
        end
        i_enable = 1'b1;
        @(negedge clock);
        n_vec++;
        if (o_led !== 4'b1000 || o_tick !== 1'b0) begin
            n_err++; $display("FAIL resume_wait got led=%b tick=%b exp led=1000 tick=0", o_led, o_tick);
        end
        @(negedge clock);
        n_vec++;
        if (o_led !== 4'b0100 || o_tick !== 1'b1) begin
            n_err++; $display("FAIL resume_tick got led=%b tick=%b exp led=0100 tick=1", o_led, o_tick);
        end
    endtask

    task automatic test_flash_color();
        logic [3:0] exp_led;
        int         hits;
        i_mode = 2'd3; i_color_sel = 2'd1;
        repeat (4) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            exp_led = (s == 0) ? 4'b1111 : 4'b0000;
            hits = 0;
            for (int c = 0; c < 4; c++) begin
                n_vec++;
                if (o_led !== exp_led || o_led_r !== 4'b0000 || o_led_b !== 4'b0000) begin
                    n_err++; $display("FAIL flash s%0d c%0d got led=%b r=%b b=%b exp led=%b r=0000 b=0000", s, c, o_led, o_led_r, o_led_b, exp_led);
                end
`ifdef SHIFTLEDS_DIM_EN
                n_vec++;
                if (o_led_g !== 4'b0000 && o_led_g !== exp_led) begin
                    n_err++; $display("FAIL flash_green_dim s%0d c%0d got %b exp %b or 0000", s, c, o_led_g, exp_led);
                end
                if (o_led_g === 4'b1111) hits++;
`else
                n_vec++;
                if (o_led_g !== exp_led) begin
                    n_err++; $display("FAIL flash_green s%0d c%0d got %b exp %b", s, c, o_led_g, exp_led);
                end
`endif
                @(negedge clock);
            end
`ifdef SHIFTLEDS_DIM_EN
            n_vec++;
            if (hits != ((s == 0) ? 1 : 0)) begin
                n_err++; $display("FAIL flash_duty s%0d got %0d lit cycles exp %0d", s, hits, (s == 0) ? 1 : 0);
            end
`endif
        end
        n_vec++;
        if (o_led !== 4'b1111 || o_tick !== 1'b1) begin
            n_err++; $display("FAIL flash_rearm got led=%b tick=%b exp led=1111 tick=1", o_led, o_tick);
        end
    endtask

    task automatic test_reset_midrun();
        #2;
        i_reset = 1'b0;
        #1;
        n_vec++;
        if (o_led !== 4'b0001 || o_tick !== 1'b0) begin
            n_err++; $display("FAIL async_reset got led=%b tick=%b exp led=0001 tick=0", o_led, o_tick);
        end
        n_vec++;
        if (o_led_g !== 4'b0001 || o_led_r !== 4'b0000 || o_led_b !== 4'b0000) begin
            n_err++; $display("FAIL async_reset_colour got r=%b g=%b b=%b exp r=0000 g=0001 b=0000", o_led_r, o_led_g, o_led_b);
        end
        @(negedge clock);
        i_reset = 1'b1; i_color_sel = 2'd3;
        repeat (3) begin
            @(negedge clock);
            n_vec++;
            if (o_tick !== 1'b0 || o_led !== 4'b0001) begin
                n_err++; $display("FAIL post_reset_idle got led=%b tick=%b exp led=0001 tick=0", o_led, o_tick);
            end
        end
        @(negedge clock);
        n_vec++;
        if (o_led !== 4'b1111 || o_tick !== 1'b1) begin
            n_err++; $display("FAIL post_reset_tick got led=%b tick=%b exp led=1111 tick=1", o_led, o_tick);
        end
        n_vec++;
        if (o_led_r !== 4'b1111 || o_led_g !== 4'b1111 || o_led_b !== 4'b1111) begin
            n_err++; $display("FAIL all_colour got r=%b g=%b b=%b exp 1111 each", o_led_r, o_led_g, o_led_b);
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_ping_pong();
        test_mode_switch();
        test_speed_change();
        test_enable_freeze();
        test_flash_color();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
